// File: rtl/ks_mp_add_seq.sv
// Multi-precision add/subtract sequencer driving one external combinational WORD_W-bit adder.
// Optional KS_SEQ_OVF_EN adds a signed-overflow output for the full-length result.
//   state   | meaning
//   S_IDLE  | waiting for start; carry_out/overflow hold the last result
//   S_RUN   | accepting operand pairs, chaining carry word to word
//   S_DRAIN | last pair taken; waiting for the final sum word to be consumed
module ks_mp_add_seq #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              sub,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_word,
   input  logic [WORD_W-1:0] b_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] sum_word,
   output logic              out_last,
   output logic [WORD_W-1:0] add_a,
   output logic [WORD_W-1:0] add_b,
   output logic              add_cin,
   input  logic [WORD_W-1:0] add_sum,
   input  logic              add_cout,
   output logic              busy,
   output logic              done,
   output logic              carry_out
`ifdef KS_SEQ_OVF_EN
   ,
   output logic              overflow
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  len_reg;
   logic              sub_reg;
   logic              carry_reg;
   logic              accept;
   logic              last_pair;

   assign add_a     = a_word;
   assign add_b     = sub_reg ? ~b_word : b_word;
   assign add_cin   = carry_reg;
   assign last_pair = (cnt == len_reg);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready && last_pair) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (out_valid && out_ready && out_last) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // cnt wraps to 0 after a max-length run; harmless because the FSM has left RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         len_reg   <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         sum_word  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         carry_out <= 1'b0;
`ifdef KS_SEQ_OVF_EN
         overflow  <= 1'b0;
`endif
      end else begin
         if (state == S_IDLE && start) begin
            cnt       <= '0;
            carry_reg <= sub;
            len_reg   <= len;
            sub_reg   <= sub;
         end
         if (accept) begin
            sum_word  <= add_sum;
            out_valid <= 1'b1;
            out_last  <= last_pair;
            carry_reg <= add_cout;
            cnt       <= cnt + 1'b1;
            if (last_pair) begin
               carry_out <= add_cout;
`ifdef KS_SEQ_OVF_EN
               overflow  <= a_word[WORD_W-1] ^ add_b[WORD_W-1] ^ add_sum[WORD_W-1] ^ add_cout;
`endif
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ks_mp_add_seq.sv
// Scoreboard bench for ks_mp_add_seq with a behavioural 8-bit adder core on the add_* ports.
module tb_ks_mp_add_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] len;
   logic       sub;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_word;
   logic [7:0] b_word;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum_word;
   logic       out_last;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_cin;
   logic [7:0] add_sum;
   logic       add_cout;
   logic       busy;
   logic       done;
   logic       carry_out;
   logic       overflow;
   logic [8:0] add_full;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [8:0] exp_q[$];
   logic [7:0] va [16];
   logic [7:0] vb [16];
   logic [7:0] ve [16];

   always #5 clk = ~clk;

   assign add_full = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
   assign add_sum  = add_full[7:0];
   assign add_cout = add_full[8];

`ifndef KS_SEQ_OVF_EN
   assign overflow = 1'b0;
`endif

   ks_mp_add_seq #(.WORD_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .a_word(a_word), .b_word(b_word),
      .out_valid(out_valid), .out_ready(out_ready), .sum_word(sum_word), .out_last(out_last),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
      .busy(busy), .done(done), .carry_out(carry_out)
`ifdef KS_SEQ_OVF_EN
      , .overflow(overflow)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever a sum word transfers
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none", sum_word);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("sum_word", {23'd0, out_last, sum_word}, {23'd0, e});
               if (out_last) chk("done_on_last", {31'd0, done}, 32'd1);
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic do_start(input logic [3:0] l, input logic s);
      start = 1'b1;
      len   = l;
      sub   = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      a_word   = a;
      b_word   = b;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (!busy) ok = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!ok) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [3:0] l, input logic s,
                         input logic exp_carry, input logic exp_ovf);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i <= int'(l); i++) exp_q.push_back({(i == int'(l)), ve[i]});
      do_start(l, s);
      for (int i = 0; i <= int'(l); i++) send_pair(va[i], vb[i]);
      wait_idle();
      chk({name, "_carry_out"}, {31'd0, carry_out}, {31'd0, exp_carry});
`ifdef KS_SEQ_OVF_EN
      chk({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
`else
      chk({name, "_ovf_tie"}, {31'd0, overflow}, {31'd0, exp_ovf & 1'b0});
`endif
      chk({name, "_done_cnt"}, done_cnt - d0, 32'd1);
      chk({name, "_q_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; len = '0; sub = 1'b0;
      in_valid = 1'b0; a_word = '0; b_word = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_carry_out", {31'd0, carry_out}, 32'd0);
      chk("rst_sum_word", {24'd0, sum_word}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      va[0] = 8'hFF; vb[0] = 8'h01; ve[0] = 8'h00;
      va[1] = 8'h00; vb[1] = 8'h00; ve[1] = 8'h01;
      run_op("add1", 4'd1, 1'b0, 1'b0, 1'b0);

      va[0] = 8'hFF; vb[0] = 8'h01; ve[0] = 8'h00;
      va[1] = 8'hFF; vb[1] = 8'h00; ve[1] = 8'h00;
      run_op("add2", 4'd1, 1'b0, 1'b1, 1'b0);

      va[0] = 8'h00; vb[0] = 8'h01; ve[0] = 8'hFF;
      va[1] = 8'h01; vb[1] = 8'h00; ve[1] = 8'h00;
      run_op("sub1", 4'd1, 1'b1, 1'b1, 1'b0);

      // 4 words with a 3-cycle output stall and stray start pulses while busy
      d0 = done_cnt;
      va[0] = 8'h12; vb[0] = 8'h34; ve[0] = 8'h46;
      va[1] = 8'hF0; vb[1] = 8'h20; ve[1] = 8'h10;
      va[2] = 8'h55; vb[2] = 8'hAA; ve[2] = 8'h00;
      va[3] = 8'h80; vb[3] = 8'h80; ve[3] = 8'h01;
      for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), ve[i]});
      do_start(4'd3, 1'b0);
      fork
         begin
            for (int i = 0; i < 4; i++) send_pair(va[i], vb[i]);
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
               if (out_valid) seen = 1'b1;
               else begin
                  @(posedge clk); #1;
               end
            end
            if (!seen) chk("stall_wait_timeout", 32'd0, 32'd1);
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
               chk("stall_sum_held", {23'd0, out_valid, sum_word}, {23'd0, 1'b1, 8'h46});
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
         begin
            @(posedge clk); #1;
            start = 1'b1; len = 4'd0; sub = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; sub = 1'b0;
            chk("busy_during_run", {31'd0, busy}, 32'd1);
         end
      join
      wait_idle();
      chk("stall_carry_out", {31'd0, carry_out}, 32'd1);
`ifdef KS_SEQ_OVF_EN
      chk("stall_overflow", {31'd0, overflow}, 32'd1);
`endif
      chk("stall_done_cnt", done_cnt - d0, 32'd1);
      chk("stall_q_empty", exp_q.size(), 32'd0);

      // maximum length: 16 words, cnt wraps after the last pair
      va[0] = 8'hFF; vb[0] = 8'h01; ve[0] = 8'h00;
      for (int i = 1; i < 16; i++) begin
         va[i] = 8'hFF; vb[i] = 8'h00; ve[i] = 8'h00;
      end
      run_op("max_len", 4'd15, 1'b0, 1'b1, 1'b0);

      // reset mid-operation after 2 of 4 words
      d0 = done_cnt;
      exp_q.push_back({1'b0, 8'h33});
      exp_q.push_back({1'b0, 8'h03});
      do_start(4'd3, 1'b0);
      send_pair(8'h11, 8'h22);
      send_pair(8'h01, 8'h02);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_carry_out", {31'd0, carry_out}, 32'd0);
      chk("abort_sum_word", {24'd0, sum_word}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_no_done", done_cnt - d0, 32'd0);
      chk("abort_q_empty", exp_q.size(), 32'd0);
      @(posedge clk); #1;

      va[0] = 8'h7F; vb[0] = 8'h01; ve[0] = 8'h80;
      run_op("post_rst", 4'd0, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
